angle_interp: RTL and testbench
===============================

Name: angle_interp

Overview:
- Sits directly downstream of the crank-wheel sync block and consumes its trigger, synced, eng_phase, tooth_period and next_tooth_length_deg outputs.
- Between tooth edges it produces a continuously advancing, sub-tooth-resolution engine angle. A phase accumulator (no divider) spreads the next tooth's angular length over the last measured tooth period.
- Drives one angle-scheduled event channel (injector/ignition-style pulse): output asserts when the interpolated angle crosses a programmed target and holds for a programmed number of clocks.

Parameters:
- FRAC_BITS, 4, fractional bits of interpolated angle below one phase unit
- CYCLE, 7200, phase units per engine cycle (0.1 deg units, 720 deg); angle wraps modulo CYCLE
- AW, 16, integer width of phase/angle values

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- trigger  in  1  one-clock tooth-edge strobe from sync block (already gated by synced)
- synced  in  1  sync-valid level from sync block
- eng_phase  in  AW  phase at the current tooth edge, valid in trigger cycle
- tooth_period  in  32  clocks in last tooth, valid in trigger cycle
- next_tooth_length_deg  in  AW  angular length of upcoming tooth, valid in trigger cycle
- target_angle  in  AW  event target, integer phase units, < CYCLE
- duration  in  32  event pulse width, clocks
- arm  in  1  level enable for event channel
- angle  out  AW+FRAC_BITS  interpolated angle, fine units
- angle_valid  out  1  angle tracks a synced wheel
- event_out  out  1  event pulse
- event_busy  out  1  pulse in progress

Behaviour:
- Async reset: angle=0, angle_valid=0, event_out=0, event_busy=0; internal base, prog, acc, period, incr_fine, duration counter all cleared.
- Trigger cycle with synced=1, registered on that edge:
  - base <= eng_phase<<FRAC_BITS
  - prog <= 0, acc <= 0
  - period <= tooth_period
  - incr_fine <= next_tooth_length_deg<<FRAC_BITS
  - angle_valid <= 1
- Non-trigger cycle while angle_valid:
  - acc <= acc + incr_fine.
  - If the sum >= period: acc <= sum - period and prog <= prog + 1.
  - Rate: at most 1 fine LSB per clock.
  - Clamp: prog never exceeds incr_fine. At that value angle holds until the next trigger; acc keeps accumulating, saturating at 2^32-1.
- angle = base + prog, reduced modulo CYCLE<<FRAC_BITS; the reduction is one conditional subtract.
  - Registered output, 1-clock latency from base/prog update.
- Widths: acc 32 bit, prog AW+FRAC_BITS, incr_fine AW+FRAC_BITS.
- period==0 on trigger: treated as 1 (no hang).
- synced falls: angle_valid <= 0 next clock; angle holds its last value; acc/prog frozen.
- trigger with synced=0: ignored.
- Event crossing:
  - Let prev_int, cur_int be the integer angle (angle>>FRAC_BITS) before and after an update.
  - Fires when arm && angle_valid && !event_busy && duration!=0 && target_angle ∈ (prev_int, cur_int] modulo CYCLE.
  - This covers normal 1-LSB steps, forward jumps at resync, and wrap 7199->0.
  - Backward jumps (base < previous angle, correction at trigger) never fire.
  - A target skipped while busy is dropped, not queued.
  - First update after angle_valid rises does not fire (prev undefined).
- Event timing:
  - event_out and event_busy rise one clock after the crossing update.
  - Down-counter loaded with duration; event_out stays high exactly `duration` clocks, then both fall.
- Abort: arm low or angle_valid low terminates the pulse in the next clock; counter is cleared.
- Simultaneous trigger and accumulator carry: trigger wins (prog <= 0).
- Reset mid-pulse: event_out drops asynchronously.

Decomposition:
- Package efi_angle_pkg:
  - FRAC_BITS, CYCLE, AW constants
  - angle_t typedef (AW+FRAC_BITS)
  - phase_t typedef (AW)
  - function wrap_angle (modulo-CYCLE conditional subtract)
  - function in_window (wrapped half-open interval test)
- Sub-module angle_event: event channel (crossing detect, duration counter, abort), instantiated once here, replicated per cylinder later.

Test Plan:
- Trigger at eng_phase=100, tooth_period=16000, next_tooth_length_deg=100 -> prog increments every 10 clocks; angle=1616 (fine) at 160 clocks after trigger; angle=3200 after 16000 clocks; clamps at 3200 until next trigger.
- Base 7150, tooth length 100, period 16000 -> angle passes 7199.xx, wraps to 0 at integer 7200, reaches integer 50 at tooth end; target 0 fires exactly once.
- target_angle=105, duration=50, arm=1, wheel as in first scenario -> event_out rises 1 clock after integer angle reaches 105; high exactly 50 clocks.
- Pulse of duration 1000 in progress, synced drops -> angle_valid=0 and event_out=0 within 1 clock; angle frozen; no refire until resync.
- Clamp at 3200, next trigger eng_phase=400 (jump across target 350) -> fires; trigger with eng_phase=150 while angle=200 (backward, target 180) -> no fire.
- Async reset asserted mid-pulse and mid-tooth -> all outputs 0 immediately; after release, no event until first valid trigger plus one crossing.

Source files
------------

// File: rtl/efi_angle_pkg.sv
// rtl/efi_angle_pkg.sv - shared constants, types and helpers for crank-angle interpolation
// Contents: FRAC_BITS/CYCLE/AW constants, angle_t (fine angle), phase_t (integer phase),
//           wrap_angle (single conditional modulo-CYCLE subtract), in_window (wrapped crossing test).
package efi_angle_pkg;

    localparam int FRAC_BITS = 4;
    localparam int CYCLE     = 7200;
    localparam int AW        = 16;
    localparam int FW        = AW + FRAC_BITS;

    typedef logic [FW-1:0] angle_t;
    typedef logic [AW-1:0] phase_t;

    localparam angle_t       CYCLE_FINE = angle_t'(CYCLE << FRAC_BITS);
    localparam logic [AW:0]  CYCLE_INT  = (AW + 1)'(CYCLE);
    localparam logic [AW:0]  HALF_CYCLE = (AW + 1)'(CYCLE / 2);

    // Inputs are at most (CYCLE<<FRAC_BITS)-1 plus one tooth, so one subtract suffices.
    function automatic angle_t wrap_angle(input logic [FW:0] a);
        angle_t r;
        if (a >= {1'b0, CYCLE_FINE}) begin
            r = angle_t'(a - {1'b0, CYCLE_FINE});
        end else begin
            r = a[FW-1:0];
        end
        return r;
    endfunction

    // True when tgt lies in (prev, cur] going forward around the cycle.
    // A forward distance of half a cycle or more is taken as a backward
    // correction and never matches, which keeps 7199->0 wraps distinct
    // from resync steps to a smaller angle.
    function automatic logic in_window(input phase_t prev, input phase_t cur, input phase_t tgt);
        logic [AW:0] d;
        logic [AW:0] dt;
        d  = (cur >= prev) ? ({1'b0, cur} - {1'b0, prev})
                           : ({1'b0, cur} + CYCLE_INT - {1'b0, prev});
        dt = (tgt >= prev) ? ({1'b0, tgt} - {1'b0, prev})
                           : ({1'b0, tgt} + CYCLE_INT - {1'b0, prev});
        return (d != '0) && (d < HALF_CYCLE) && (dt != '0) && (dt <= d);
    endfunction

endpackage

// File: rtl/angle_event.sv
// rtl/angle_event.sv - angle-scheduled event channel: crossing detect, pulse counter, abort
// Ports: clk, reset_n (async active-low); angle (fine angle), angle_ok (angle reflects synced data),
//        valid_now (next-cycle angle_valid), target_angle, duration, arm; event_out, event_busy.
module angle_event
    import efi_angle_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [FW-1:0] angle,
    input  logic          angle_ok,
    input  logic          valid_now,
    input  logic [AW-1:0] target_angle,
    input  logic [31:0]   duration,
    input  logic          arm,
    output logic          event_out,
    output logic          event_busy
);

    phase_t      cur_int;
    phase_t      prev_int_q, prev_int_d;
    logic        prev_ok_q, prev_ok_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fire;

    assign cur_int = angle[FW-1:FRAC_BITS];

    always_comb begin
        prev_int_d = cur_int;
        prev_ok_d  = angle_ok;
        cnt_d      = cnt_q;
        fire       = 1'b0;
        if (!arm || !valid_now) begin
            cnt_d = '0;
        end else begin
            // prev_ok_q gates the first sample after valid rises (no prior angle).
            fire = angle_ok && prev_ok_q && (cnt_q == '0) && (duration != '0) &&
                   in_window(prev_int_q, cur_int, target_angle);
            if (fire) begin
                cnt_d = duration;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_int_q <= '0;
            prev_ok_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            prev_int_q <= prev_int_d;
            prev_ok_q  <= prev_ok_d;
            cnt_q      <= cnt_d;
        end
    end

    assign event_busy = (cnt_q != '0);
    assign event_out  = event_busy;

endmodule

// File: rtl/angle_interp.sv
// rtl/angle_interp.sv - sub-tooth engine angle interpolator with one angle-scheduled event channel
// Ports: clk, reset_n (async active-low); trigger, synced, eng_phase, tooth_period,
//        next_tooth_length_deg from the sync block; target_angle, duration, arm for the event;
//        angle (fine units), angle_valid, event_out, event_busy.
module angle_interp
    import efi_angle_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trigger,
    input  logic          synced,
    input  logic [AW-1:0] eng_phase,
    input  logic [31:0]   tooth_period,
    input  logic [AW-1:0] next_tooth_length_deg,
    input  logic [AW-1:0] target_angle,
    input  logic [31:0]   duration,
    input  logic          arm,
    output logic [FW-1:0] angle,
    output logic          angle_valid,
    output logic          event_out,
    output logic          event_busy
);

    angle_t      base_q, base_d;
    angle_t      prog_q, prog_d;
    angle_t      incr_q, incr_d;
    angle_t      angle_q, angle_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        valid_dly_q;
    logic [32:0] sum;
    logic [32:0] rem;
    logic        carry;

    // Phase accumulator: adding incr per clock and subtracting period on carry
    // spreads incr fine steps evenly across period clocks without a divider.
    always_comb begin
        sum   = {1'b0, acc_q} + 33'(incr_q);
        carry = (sum >= {1'b0, period_q});
        rem   = carry ? (sum - {1'b0, period_q}) : sum;

        base_d   = base_q;
        prog_d   = prog_q;
        incr_d   = incr_q;
        acc_d    = acc_q;
        period_d = period_q;
        valid_d  = valid_q;

        if (trigger && synced) begin
            base_d   = angle_t'({eng_phase, {FRAC_BITS{1'b0}}});
            prog_d   = '0;
            acc_d    = '0;
            period_d = (tooth_period == '0) ? 32'd1 : tooth_period;
            incr_d   = angle_t'({next_tooth_length_deg, {FRAC_BITS{1'b0}}});
            valid_d  = 1'b1;
        end else if (!synced) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (prog_q < incr_q) begin
                acc_d = rem[32] ? '1 : rem[31:0];
                if (carry) begin
                    prog_d = prog_q + 1'b1;
                end
            end else begin
                // Clamped: angle holds until the next tooth, acc only saturates.
                acc_d = sum[32] ? '1 : sum[31:0];
            end
        end

        angle_d = wrap_angle({1'b0, base_q} + {1'b0, prog_q});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q      <= '0;
            prog_q      <= '0;
            incr_q      <= '0;
            acc_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            valid_dly_q <= 1'b0;
            angle_q     <= '0;
        end else begin
            base_q      <= base_d;
            prog_q      <= prog_d;
            incr_q      <= incr_d;
            acc_q       <= acc_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            valid_dly_q <= valid_q;
            angle_q     <= angle_d;
        end
    end

    assign angle       = angle_q;
    assign angle_valid = valid_q;

    // angle lags base/prog by one clock, so the event channel only trusts the
    // angle once valid has been high for a full cycle; it aborts on valid_d so
    // the pulse drops on the same edge as angle_valid.
    angle_event u_event (
        .clk          (clk),
        .reset_n      (reset_n),
        .angle        (angle_q),
        .angle_ok     (valid_q && valid_dly_q),
        .valid_now    (valid_d),
        .target_angle (target_angle),
        .duration     (duration),
        .arm          (arm),
        .event_out    (event_out),
        .event_busy   (event_busy)
    );

endmodule

// File: tb/tb_angle_interp.sv
// tb/tb_angle_interp.sv - directed self-checking bench for angle_interp
module tb_angle_interp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trigger;
    logic        synced;
    logic [15:0] eng_phase;
    logic [31:0] tooth_period;
    logic [15:0] next_tooth_length_deg;
    logic [15:0] target_angle;
    logic [31:0] duration;
    logic        arm;
    logic [19:0] angle;
    logic        angle_valid;
    logic        event_out;
    logic        event_busy;

    int total = 0;
    int bad   = 0;

    angle_interp dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .trigger               (trigger),
        .synced                (synced),
        .eng_phase             (eng_phase),
        .tooth_period          (tooth_period),
        .next_tooth_length_deg (next_tooth_length_deg),
        .target_angle          (target_angle),
        .duration              (duration),
        .arm                   (arm),
        .angle                 (angle),
        .angle_valid           (angle_valid),
        .event_out             (event_out),
        .event_busy            (event_busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_trigger(input int ph, input int per, input int len);
        trigger               = 1'b1;
        synced                = 1'b1;
        eng_phase             = 16'(ph);
        tooth_period          = 32'(per);
        next_tooth_length_deg = 16'(len);
        tick(1);
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trigger = 1'b0; synced = 1'b0; arm = 1'b0;
        eng_phase = '0; tooth_period = '0; next_tooth_length_deg = '0;
        target_angle = '0; duration = '0;
        tick(3);
        total++; if (angle !== 20'd0) begin bad++; $display("FAIL reset_angle: got %0d want 0", angle); end
        total++; if (angle_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", angle_valid); end
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL reset_event: got %b want 0", event_out); end
        total++; if (event_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", event_busy); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_interp();
        arm = 1'b0;
        do_trigger(100, 16000, 100);
        tick(160);
        total++; if (angle !== 20'd1615) begin bad++; $display("FAIL interp_160: got %0d want 1615", angle); end
        tick(1);
        total++; if (angle !== 20'd1616) begin bad++; $display("FAIL interp_161: got %0d want 1616", angle); end
        total++; if (angle_valid !== 1'b1) begin bad++; $display("FAIL interp_valid: got %b want 1", angle_valid); end
        tick(15839);
        total++; if (angle !== 20'd3199) begin bad++; $display("FAIL interp_16000: got %0d want 3199", angle); end
        tick(1);
        total++; if (angle !== 20'd3200) begin bad++; $display("FAIL interp_16001: got %0d want 3200", angle); end
        tick(300);
        total++; if (angle !== 20'd3200) begin bad++; $display("FAIL interp_clamp: got %0d want 3200", angle); end
    endtask

    task automatic test_jump();
        int fires;
        target_angle = 16'd350; duration = 32'd10; arm = 1'b1;
        tick(5);
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL jump_idle: got %b want 0", event_out); end
        do_trigger(400, 16000, 100);
        tick(1);
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL jump_e1: got %b want 0", event_out); end
        tick(1);
        total++; if (event_out !== 1'b1) begin bad++; $display("FAIL jump_fire: got %b want 1", event_out); end
        tick(20);
        do_trigger(200, 16000, 100);
        tick(3);
        target_angle = 16'd180;
        tick(2);
        do_trigger(150, 16000, 100);
        fires = 0;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (event_out === 1'b1) fires++;
        end
        total++; if (fires !== 0) begin bad++; $display("FAIL backward_nofire: got %0d high cycles want 0", fires); end
    endtask

    task automatic test_event();
        target_angle = 16'd105; duration = 32'd50; arm = 1'b1;
        do_trigger(100, 16000, 100);
        tick(801);
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL event_pre: got %b want 0", event_out); end
        tick(1);
        total++; if (event_out !== 1'b1) begin bad++; $display("FAIL event_rise: got %b want 1", event_out); end
        total++; if (event_busy !== 1'b1) begin bad++; $display("FAIL event_busy_rise: got %b want 1", event_busy); end
        tick(49);
        total++; if (event_out !== 1'b1) begin bad++; $display("FAIL event_last: got %b want 1", event_out); end
        tick(1);
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL event_fall: got %b want 0", event_out); end
        total++; if (event_busy !== 1'b0) begin bad++; $display("FAIL event_busy_fall: got %b want 0", event_busy); end
    endtask

    task automatic test_sync_drop();
        target_angle = 16'd110; duration = 32'd1000; arm = 1'b1;
        do_trigger(100, 16000, 100);
        tick(1702);
        total++; if (event_out !== 1'b1) begin bad++; $display("FAIL drop_active: got %b want 1", event_out); end
        synced = 1'b0;
        tick(1);
        total++; if (angle_valid !== 1'b0) begin bad++; $display("FAIL drop_valid: got %b want 0", angle_valid); end
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL drop_event: got %b want 0", event_out); end
        total++; if (angle !== 20'd1770) begin bad++; $display("FAIL drop_angle: got %0d want 1770", angle); end
        tick(50);
        total++; if (angle !== 20'd1770) begin bad++; $display("FAIL drop_frozen: got %0d want 1770", angle); end
        synced = 1'b1;
        tick(20);
        total++; if (angle_valid !== 1'b0) begin bad++; $display("FAIL drop_novalid: got %b want 0", angle_valid); end
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL drop_norefire: got %b want 0", event_out); end
    endtask

    task automatic test_reset_mid();
        target_angle = 16'd105; duration = 32'd50; arm = 1'b1;
        do_trigger(100, 16000, 100);
        tick(810);
        total++; if (event_out !== 1'b1) begin bad++; $display("FAIL rmid_active: got %b want 1", event_out); end
        reset_n = 1'b0;
        #1;
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL rmid_event: got %b want 0", event_out); end
        total++; if (event_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", event_busy); end
        total++; if (angle !== 20'd0) begin bad++; $display("FAIL rmid_angle: got %0d want 0", angle); end
        total++; if (angle_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", angle_valid); end
        tick(2);
        reset_n = 1'b1;
        tick(50);
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL rmid_quiet: got %b want 0", event_out); end
        do_trigger(100, 16000, 100);
        tick(801);
        total++; if (event_out !== 1'b0) begin bad++; $display("FAIL rmid_pre: got %b want 0", event_out); end
        tick(1);
        total++; if (event_out !== 1'b1) begin bad++; $display("FAIL rmid_refire: got %b want 1", event_out); end
    endtask

    task automatic test_wrap();
        int   rises;
        logic prev_ev;
        target_angle = 16'd0; duration = 32'd20; arm = 1'b1;
        do_trigger(7150, 16000, 100);
        rises   = 0;
        prev_ev = event_out;
        for (int k = 1; k <= 16005; k++) begin
            tick(1);
            if (event_out === 1'b1 && prev_ev === 1'b0) rises++;
            prev_ev = event_out;
            if (k == 8000) begin
                total++; if (angle !== 20'd115199) begin bad++; $display("FAIL wrap_pre: got %0d want 115199", angle); end
            end
            if (k == 8001) begin
                total++; if (angle !== 20'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", angle); end
            end
        end
        total++; if (rises !== 1) begin bad++; $display("FAIL wrap_fires: got %0d want 1", rises); end
        total++; if (angle !== 20'd800) begin bad++; $display("FAIL wrap_end: got %0d want 800", angle); end
    endtask

    task automatic test_period_zero();
        arm = 1'b0;
        do_trigger(500, 0, 1);
        tick(5);
        total++; if (angle !== 20'd8004) begin bad++; $display("FAIL pzero_step: got %0d want 8004", angle); end
        tick(15);
        total++; if (angle !== 20'd8016) begin bad++; $display("FAIL pzero_clamp: got %0d want 8016", angle); end
        tick(20);
        total++; if (angle !== 20'd8016) begin bad++; $display("FAIL pzero_hold: got %0d want 8016", angle); end
    endtask

    initial begin
        test_reset();
        test_interp();
        test_jump();
        test_event();
        test_sync_drop();
        test_reset_mid();
        test_wrap();
        test_period_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
